wb_lap_reader: RTL and testbench
================================

// Module: wb_lap_reader
// PURPOSE
//  Wishbone classic read-only master that reads saved lap times back out of sram_2port through
//  wb_bus_interconnect / wb_slave_wrapper. It is the reader end of the lap-store path that the
//  timer writes through wb_master_wrapper. It fetches one 16-bit lap record per request, holds
//  it for the 7-segment display, and steps through records on next, wrapping at the end.
// PARAMETERS
//  ADDR_W      8    Wishbone address width (word address)
//  DATA_W      16   Wishbone data width, one lap record per word
//  TIMEOUT     15   max cycles with cyc/stb high and no ack before abort; >=1
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous reset, active low
//  start        in   1       1-cycle pulse: (re)start readout at record 0
//  next         in   1       1-cycle pulse (debounced next_saved): advance to following record
//  base_addr    in   ADDR_W  address of record 0, sampled on start
//  num_words    in   ADDR_W  number of stored records, sampled on start
//  lap_data     out  DATA_W  last record read
//  lap_valid    out  1       lap_data holds record lap_idx
//  lap_idx      out  ADDR_W  index of record in lap_data / being fetched
//  busy         out  1       Wishbone transaction in progress
//  err          out  1       sticky: last fetch timed out; cleared by start
//  wb_cyc_o     out  1       Wishbone cycle
//  wb_stb_o     out  1       Wishbone strobe (always equal to wb_cyc_o)
//  wb_we_o      out  1       tied 0 (read-only master)
//  wb_adr_o     out  ADDR_W  base + lap_idx, modulo 2^ADDR_W
//  wb_dat_o     out  DATA_W  tied 0
//  wb_dat_i     in   DATA_W  read data from slave
//  wb_ack_i     in   1       slave acknowledge
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 (lap_data, lap_idx, lap_valid, busy, err, cyc/stb/adr).
//  - All outputs are registered; a reset asserted mid-transaction drops cyc/stb asynchronously.
//  - FSM states: IDLE, REQ, HOLD.
//  - IDLE: start with num_words!=0 -> latch base/num, idx=0, err=0, lap_valid=0, go REQ.
//    start with num_words==0 -> stay IDLE, lap_valid=0, err=0. next is ignored in IDLE.
//  - REQ: cyc=stb=1, adr=base+idx. These are high from the edge after start/next is sampled.
//    On the first edge where wb_ack_i=1: lap_data<=wb_dat_i, lap_valid<=1, cyc/stb<=0, go HOLD.
//    Latency is 1 cycle plus the slave ack delay. wb_ack_i while not in REQ is ignored.
//  - Timeout: the cycle counter resets on entry to REQ. If TIMEOUT cycles pass without ack:
//    cyc/stb<=0, err<=1, lap_valid<=0, go IDLE.
//  - HOLD: next -> idx<=(idx==num-1)?0:idx+1, lap_valid<=0, go REQ.
//    start -> restart exactly as from IDLE, with fresh base/num.
//  - Simultaneous start and next: start wins. start or next during REQ: ignored (not queued).
//    The transaction always completes or times out; no mid-cycle abort.
//  - Address arithmetic wraps modulo 2^ADDR_W (base=0xFE, idx=3 -> adr=0x01).
//  - busy==(state==REQ). The master never asserts cyc without stb and holds adr stable while stb=1.
// STRUCTURE
//  - Shared package / include: WB address and data widths, FSM state encodings
//    (reused by wb_master_wrapper).
//  - Single flat module; the timeout counter stays inline (no sub-module warranted).
//  - Instantiated alongside the timer; it shares the bus with wb_master_wrapper through an
//    arbiter added in the top level.
// TESTING
//  1 reset mid-REQ: rst_n low while cyc=1 -> cyc/stb/lap_valid drop same cycle, all outputs 0.
//  2 base=0x10, num=3, slave ack 1 cycle after stb, mem[0x10..12]=0x0123,0x0456,0x0789:
//    start -> adr 0x10, lap_data=0x0123, lap_valid=1; next x3 -> 0x0456, 0x0789, 0x0123 (wrap, idx 0).
//  3 num=0: start -> no cyc ever asserted, lap_valid=0, busy=0.
//  4 slave never acks, TIMEOUT=15: start -> cyc high exactly 15 cycles, then err=1, IDLE;
//    next start -> err=0.
//  5 next pulsed during REQ and start+next same cycle in HOLD -> next ignored; restart at
//    idx 0, adr=base.
//  6 base=0xFE, num=4: step through -> adr sequence 0xFE,0xFF,0x00,0x01,0xFE; we_o always 0.

Source files
------------

// File: rtl/wb_lap_reader_pkg.sv
// Shared definitions for the lap-store Wishbone path.
// Holds the bus widths and the FSM state encodings used by wb_lap_reader; the
// same encodings are reused by wb_master_wrapper so both masters report state
// the same way on debug taps.
package wb_lap_reader_pkg;

    // Word address and one lap record per data word.
    localparam int unsigned WB_ADDR_W = 8;
    localparam int unsigned WB_DATA_W = 16;

    // Master FSM state encoding.
    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] wb_state_t;

    localparam wb_state_t ST_IDLE = 2'd0;
    localparam wb_state_t ST_REQ  = 2'd1;
    localparam wb_state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/wb_lap_reader_if.sv
// Wishbone classic bus bundle between a lap-store master and its slave.
// Signal names carry the master's point of view (_o driven by the master,
// _i driven by the slave).
//   wb_cyc_o / wb_stb_o  cycle and strobe
//   wb_we_o              write enable
//   wb_adr_o             word address
//   wb_dat_o             write data
//   wb_dat_i             read data
//   wb_ack_i             slave acknowledge
interface wb_lap_reader_if
    import wb_lap_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W
) ();

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;

    modport master (
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_adr_o,
        output wb_dat_o,
        input  wb_dat_i,
        input  wb_ack_i
    );

    modport slave (
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_adr_o,
        input  wb_dat_o,
        output wb_dat_i,
        output wb_ack_i
    );

endinterface

// File: rtl/wb_lap_reader.sv
// Read-only Wishbone classic master that fetches saved lap records for the
// 7-segment display. start fetches record 0 from base_addr, next steps to the
// following record (wrapping after num_words records). A fetch that sees no
// ack within TIMEOUT cycles is abandoned and flagged on err.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, next           one-cycle request pulses (start wins over next)
//   base_addr, num_words  record window, sampled on start
//   lap_data, lap_valid   last record read and its validity
//   lap_idx               index of the record held / being fetched
//   busy                  Wishbone transaction in progress
//   err                   sticky timeout flag, cleared by start
//   wb                    Wishbone master port
module wb_lap_reader
    import wb_lap_reader_pkg::*;
#(
    parameter int unsigned ADDR_W  = WB_ADDR_W,
    parameter int unsigned DATA_W  = WB_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              next,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic [DATA_W-1:0] lap_data,
    output logic              lap_valid,
    output logic [ADDR_W-1:0] lap_idx,
    output logic              busy,
    output logic              err,
    wb_lap_reader_if.master   wb
);

    // Wide enough to hold TIMEOUT-1, the last count before abort.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [ADDR_W-1:0] num_q,   num_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [ADDR_W-1:0] adr_q,   adr_d;
    logic              cyc_q,   cyc_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        idx_d   = idx_q;
        adr_d   = adr_q;
        cyc_d   = cyc_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start) begin
                    // Restart behaves identically from IDLE and HOLD.
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                    if (num_words != '0) begin
                        base_d  = base_addr;
                        num_d   = num_words;
                        idx_d   = '0;
                        adr_d   = base_addr;
                        cyc_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (next && state_q == ST_HOLD) begin
                    idx_d   = (idx_q == num_q - ADDR_W'(1)) ? '0 : idx_q + ADDR_W'(1);
                    adr_d   = base_q + idx_d;  // wraps modulo 2^ADDR_W
                    valid_d = 1'b0;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the last allowed edge still completes the fetch.
                if (wb.wb_ack_i) begin
                    data_d  = wb.wb_dat_i;
                    valid_d = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            adr_q   <= '0;
            cyc_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
            cyc_q   <= cyc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // cyc_q is high exactly while in REQ, so it doubles as busy and stb.
    assign busy        = cyc_q;
    assign lap_data    = data_q;
    assign lap_valid   = valid_q;
    assign lap_idx     = idx_q;
    assign err         = err_q;

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = '0;

endmodule

// File: tb/tb_wb_lap_reader.sv
module tb_wb_lap_reader;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       next = 1'b0;
    logic [7:0] base_addr = '0;
    logic [7:0] num_words = '0;
    logic [15:0] lap_data;
    logic       lap_valid;
    logic [7:0] lap_idx;
    logic       busy;
    logic       err;

    wb_lap_reader_if #(.ADDR_W(8), .DATA_W(16)) wb_if ();

    wb_lap_reader #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .next      (next),
        .base_addr (base_addr),
        .num_words (num_words),
        .lap_data  (lap_data),
        .lap_valid (lap_valid),
        .lap_idx   (lap_idx),
        .busy      (busy),
        .err       (err),
        .wb        (wb_if)
    );

    always #5 clk = ~clk;

    // Slave: memory with registered ack after ack_delay extra wait cycles.
    logic [15:0] mem [256];
    int          ack_delay = 0;
    logic        no_ack = 1'b0;
    int          wcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_if.wb_ack_i <= 1'b0;
            wb_if.wb_dat_i <= '0;
            wcnt           <= 0;
        end else if (wb_if.wb_cyc_o && wb_if.wb_stb_o && !wb_if.wb_ack_i && !no_ack) begin
            if (wcnt == ack_delay) begin
                wb_if.wb_ack_i <= 1'b1;
                wb_if.wb_dat_i <= mem[wb_if.wb_adr_o];
                wcnt           <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wb_if.wb_ack_i <= 1'b0;
            wcnt           <= 0;
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model: the record window and the record currently selected.
    logic [7:0] base_m, num_m, idx_m;
    logic       in_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the request pulse; follows the fetch to its end.
    task automatic run_fetch(input string tag);
        logic [7:0] exp_adr;
        int         exp_cycles;
        bit         timed_out;
        bit         proto_ok;
        int         n;
        exp_adr   = 8'((int'(base_m) + int'(idx_m)) % 256);
        timed_out = no_ack || (ack_delay + 2 > TIMEOUT);
        exp_cycles = timed_out ? TIMEOUT : ack_delay + 2;
        check({tag, " adr"}, {24'd0, wb_if.wb_adr_o}, {24'd0, exp_adr});
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        proto_ok = 1'b1;
        n = 0;
        while (wb_if.wb_cyc_o && n < 40) begin
            if (wb_if.wb_stb_o !== 1'b1 || wb_if.wb_we_o !== 1'b0 ||
                wb_if.wb_adr_o !== exp_adr || lap_valid !== 1'b0 || busy !== 1'b1)
                proto_ok = 1'b0;
            n++;
            tick();
        end
        check({tag, " bus protocol"}, {31'd0, proto_ok}, 32'd1);
        check({tag, " cyc cycles"}, n, exp_cycles);
        check({tag, " busy after"}, {31'd0, busy}, 32'd0);
        check({tag, " stb after"}, {31'd0, wb_if.wb_stb_o}, 32'd0);
        if (timed_out) begin
            check({tag, " err"}, {31'd0, err}, 32'd1);
            check({tag, " lap_valid"}, {31'd0, lap_valid}, 32'd0);
            in_hold = 1'b0;
        end else begin
            check({tag, " err"}, {31'd0, err}, 32'd0);
            check({tag, " lap_valid"}, {31'd0, lap_valid}, 32'd1);
            check({tag, " lap_data"}, {16'd0, lap_data}, {16'd0, mem[exp_adr]});
            check({tag, " lap_idx"}, {24'd0, lap_idx}, {24'd0, idx_m});
            in_hold = 1'b1;
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] num, input bit with_next);
        base_addr = b;
        num_words = num;
        start = 1'b1;
        next = with_next;
        tick();
        start = 1'b0;
        next = 1'b0;
        if (num != 0) begin
            base_m = b;
            num_m  = num;
            idx_m  = 0;
            run_fetch("start");
        end else begin
            in_hold = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check("num0 cyc", {31'd0, wb_if.wb_cyc_o}, 32'd0);
                tick();
            end
            check("num0 lap_valid", {31'd0, lap_valid}, 32'd0);
            check("num0 busy", {31'd0, busy}, 32'd0);
            check("num0 err", {31'd0, err}, 32'd0);
        end
    endtask

    task automatic do_next();
        next = 1'b1;
        tick();
        next = 1'b0;
        if (in_hold) begin
            idx_m = 8'((int'(idx_m) + 1) % int'(num_m));
            run_fetch("next");
        end else begin
            check("next idle cyc", {31'd0, wb_if.wb_cyc_o}, 32'd0);
            tick();
            check("next idle cyc2", {31'd0, wb_if.wb_cyc_o}, 32'd0);
        end
    endtask

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  num;
        int          steps;
        int          delay;
        logic [7:0]  exp_idx;
        logic [7:0]  exp_adr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'hA500 | 16'(a);
        mem[8'h10] = 16'h0123;
        mem[8'h11] = 16'h0456;
        mem[8'h12] = 16'h0789;

        vecs[0] = '{8'h10, 8'd3,   3, 0,  8'd0, 8'h10, 16'h0123};
        vecs[1] = '{8'h10, 8'd3,   2, 1,  8'd2, 8'h12, 16'h0789};
        vecs[2] = '{8'hFE, 8'd4,   3, 2,  8'd3, 8'h01, 16'hA501};
        vecs[3] = '{8'hFE, 8'd4,   4, 0,  8'd0, 8'hFE, 16'hA5FE};
        vecs[4] = '{8'h00, 8'd1,   2, 13, 8'd0, 8'h00, 16'hA500};
        vecs[5] = '{8'hF0, 8'd255, 1, 0,  8'd1, 8'hF1, 16'hA5F1};

        // Reset state.
        #2;
        check("reset cyc", {31'd0, wb_if.wb_cyc_o}, 32'd0);
        check("reset stb", {31'd0, wb_if.wb_stb_o}, 32'd0);
        check("reset adr", {24'd0, wb_if.wb_adr_o}, 32'd0);
        check("reset outs", {lap_data, lap_idx, 5'd0, lap_valid, busy, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven walks, including address wrap and the last-edge ack.
        foreach (vecs[v]) begin
            ack_delay = vecs[v].delay;
            do_start(vecs[v].base, vecs[v].num, 1'b0);
            for (int s = 0; s < vecs[v].steps; s++) do_next();
            check("vec idx", {24'd0, lap_idx}, {24'd0, vecs[v].exp_idx});
            check("vec adr", {24'd0, wb_if.wb_adr_o}, {24'd0, vecs[v].exp_adr});
            check("vec data", {16'd0, lap_data}, {16'd0, vecs[v].exp_data});
        end

        // num=0 from HOLD and from IDLE.
        do_start(8'h33, 8'd0, 1'b0);
        do_start(8'h33, 8'd0, 1'b0);
        do_next();

        // Timeout: slave never acks; then ack one cycle too late.
        no_ack = 1'b1;
        do_start(8'h20, 8'd5, 1'b0);
        do_next();
        no_ack = 1'b0;
        ack_delay = 14;
        do_start(8'h20, 8'd5, 1'b0);
        ack_delay = 0;
        do_start(8'h20, 8'd5, 1'b0);

        // next during REQ is dropped.
        ack_delay = 3;
        base_addr = 8'h20;
        num_words = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        next = 1'b1;
        tick();
        next = 1'b0;
        for (int i = 0; i < 40 && wb_if.wb_cyc_o; i++) tick();
        tick();
        check("req next cyc", {31'd0, wb_if.wb_cyc_o}, 32'd0);
        check("req next idx", {24'd0, lap_idx}, 32'd0);
        check("req next data", {16'd0, lap_data}, {16'd0, mem[8'h20]});
        base_m = 8'h20; num_m = 8'd5; idx_m = 0; in_hold = 1'b1;
        do_next();
        // start and next together: start wins with the new window.
        do_start(8'h40, 8'd2, 1'b1);

        // Reset while a transaction is open.
        no_ack = 1'b1;
        base_addr = 8'h55;
        num_words = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre-reset cyc", {31'd0, wb_if.wb_cyc_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset cyc", {31'd0, wb_if.wb_cyc_o}, 32'd0);
        check("async reset stb", {31'd0, wb_if.wb_stb_o}, 32'd0);
        check("async reset adr", {24'd0, wb_if.wb_adr_o}, 32'd0);
        check("async reset outs", {lap_data, lap_idx, 5'd0, lap_valid, busy, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        no_ack = 1'b0;
        in_hold = 1'b0;
        tick();

        // Randomised walks against the model.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] b;
            logic [7:0] num;
            b   = 8'($urandom);
            num = (r % 4 == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(1, 255));
            ack_delay = $urandom_range(0, 6);
            do_start(b, num, 1'($urandom_range(0, 1)));
            for (int s = 0; s < int'($urandom_range(1, 6)); s++) begin
                ack_delay = $urandom_range(0, 6);
                if ($urandom_range(0, 9) == 0) ack_delay = 13 + $urandom_range(0, 1);
                if (in_hold) do_next();
                else do_start(b, num, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
